video_timing_detector: RTL and testbench

Receive-side counterpart of the display timing generator: consumes a DE/HS/VS raster stream, measures its geometry (total and active pixels per line, total and active lines per frame), recovers per-pixel coordinates, and declares lock once the timing is stable. It sits at the input of capture, loopback-check and scaler paths. It also lets the bench self-check generator output.

---
 rtl/video_timing_detector.sv | 176 +++++++++++++++++
 tb/tb_video_timing_detector.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/video_timing_detector.sv
// rtl/video_timing_detector.sv - measures DE/HS/VS raster geometry, recovers pixel coordinates, declares lock
module video_timing_detector #(
    parameter int LOCK_FRAMES = 2,
    parameter int TIMEOUT     = 4095
) (
    input  logic        iClk,
    input  logic        iRst_n,
    input  logic        iDE,
    input  logic        iHS,
    input  logic        iVS,
    output logic        oDE,
    output logic        oHS,
    output logic        oVS,
    output logic [11:0] oX,
    output logic [10:0] oY,
    output logic [11:0] oHTotal,
    output logic [11:0] oHActive,
    output logic [10:0] oVTotal,
    output logic [10:0] oVActive,
    output logic        oLocked,
    output logic        oFrameStart,
    output logic        oErr
);

    localparam int TW = $clog2(TIMEOUT + 1) + 1;

    typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

    function automatic logic [11:0] inc12(input logic [11:0] v);
        inc12 = (&v) ? v : v + 12'd1;
    endfunction

    function automatic logic [10:0] inc11(input logic [10:0] v);
        inc11 = (&v) ? v : v + 11'd1;
    endfunction

    logic          r_de1, r_hs1, r_vs1, r_de2, r_hs2, r_vs2, r_arm;
    logic [11:0]   r_hcnt, r_hline, r_decnt, r_deline, r_x;
    logic [10:0]   r_linecnt, r_actcnt, r_y;
    logic [TW-1:0] r_to;
    logic [11:0]   r_m_ht, r_m_ha;
    logic [10:0]   r_m_vt, r_m_va;
    logic [7:0]    r_mcnt;
    state_t        r_state;
    logic          r_fs, r_err;

    logic          w_hs_fall, w_vs_fall, w_de_rise, w_de_fall, w_timeout, w_match;
    logic [11:0]   w_f_ht, w_f_ha;
    logic [10:0]   w_f_vt, w_f_va;
    state_t        w_state_n;
    logic [7:0]    w_mcnt_n;
    logic          w_update, w_err;

    // r_arm masks the first compare after reset, where stage 2 still holds the reset value
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_de1 <= 1'b0; r_hs1 <= 1'b1; r_vs1 <= 1'b1;
            r_de2 <= 1'b0; r_hs2 <= 1'b1; r_vs2 <= 1'b1;
            r_arm <= 1'b0;
        end else begin
            r_de1 <= iDE;   r_hs1 <= iHS;   r_vs1 <= iVS;
            r_de2 <= r_de1; r_hs2 <= r_hs1; r_vs2 <= r_vs1;
            r_arm <= 1'b1;
        end
    end

    assign w_hs_fall = r_arm &  r_hs2 & ~r_hs1;
    assign w_vs_fall = r_arm &  r_vs2 & ~r_vs1;
    assign w_de_rise = r_arm & ~r_de2 &  r_de1;
    assign w_de_fall = r_arm &  r_de2 & ~r_de1;

    // Frame totals include an HS/DE fall that coincides with the closing VS fall
    assign w_f_ht = w_hs_fall ? r_hcnt : r_hline;
    assign w_f_ha = w_de_fall ? r_decnt : r_deline;
    assign w_f_vt = w_hs_fall ? inc11(r_linecnt) : r_linecnt;
    assign w_f_va = w_de_fall ? inc11(r_actcnt) : r_actcnt;
    assign w_match = (w_f_ht == r_m_ht) && (w_f_ha == r_m_ha) &&
                     (w_f_vt == r_m_vt) && (w_f_va == r_m_va);
    assign w_timeout = !w_hs_fall && (r_to == TW'(TIMEOUT - 1));

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_hcnt    <= '0; r_hline  <= '0;
            r_decnt   <= '0; r_deline <= '0;
            r_linecnt <= '0; r_actcnt <= '0;
            r_x       <= '0; r_y      <= '0;
            r_to      <= '0;
        end else begin
            r_hcnt <= w_hs_fall ? 12'd1 : inc12(r_hcnt);
            if (w_hs_fall) r_hline <= r_hcnt;
            if (w_de_rise)  r_decnt <= 12'd1;
            else if (r_de1) r_decnt <= inc12(r_decnt);
            if (w_de_fall) r_deline <= r_decnt;
            if (w_vs_fall)      r_linecnt <= '0;
            else if (w_hs_fall) r_linecnt <= inc11(r_linecnt);
            if (w_vs_fall)      r_actcnt <= '0;
            else if (w_de_fall) r_actcnt <= inc11(r_actcnt);
            if (w_de_rise)  r_x <= '0;
            else if (r_de1) r_x <= r_x + 12'd1;
            if (w_vs_fall)      r_y <= '0;
            else if (w_de_fall) r_y <= r_y + 11'd1;
            if (w_hs_fall)                   r_to <= '0;
            else if (r_to != TW'(TIMEOUT))   r_to <= r_to + 1'b1;
        end
    end

    // The stored set always equals the last closed frame, so it also drives the measurement outputs
    always_comb begin
        w_state_n = r_state;
        w_mcnt_n  = r_mcnt;
        w_update  = 1'b0;
        w_err     = 1'b0;
        if (w_timeout) begin
            w_state_n = IDLE;
            w_mcnt_n  = '0;
            w_err     = (r_state == LOCKED);
        end else if (w_vs_fall) begin
            case (r_state)
                IDLE: begin
                    w_state_n = ACQUIRE;
                    w_mcnt_n  = '0;
                end
                ACQUIRE: begin
                    w_update = 1'b1;
                    w_mcnt_n = w_match ? ((&r_mcnt) ? r_mcnt : r_mcnt + 8'd1) : 8'd1;
                    if (int'(w_mcnt_n) >= LOCK_FRAMES) w_state_n = LOCKED;
                end
                LOCKED: begin
                    w_update = 1'b1;
                    if (!w_match) begin
                        w_err     = 1'b1;
                        w_mcnt_n  = 8'd1;
                        w_state_n = ACQUIRE;
                    end
                end
                default: w_state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            r_state <= IDLE;
            r_mcnt  <= '0;
            r_m_ht  <= '0; r_m_ha <= '0; r_m_vt <= '0; r_m_va <= '0;
            r_fs    <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_mcnt  <= w_mcnt_n;
            if (w_update) begin
                r_m_ht <= w_f_ht; r_m_ha <= w_f_ha;
                r_m_vt <= w_f_vt; r_m_va <= w_f_va;
            end
            r_fs  <= w_vs_fall;
            r_err <= w_err;
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            oDE <= 1'b0; oHS <= 1'b1; oVS <= 1'b1;
            oX  <= '0;   oY  <= '0;
            oHTotal <= '0; oHActive <= '0; oVTotal <= '0; oVActive <= '0;
            oLocked <= 1'b0; oFrameStart <= 1'b0; oErr <= 1'b0;
        end else begin
            oDE <= r_de2; oHS <= r_hs2; oVS <= r_vs2;
            oX  <= r_x;   oY  <= r_y;
            oHTotal <= r_m_ht; oHActive <= r_m_ha; oVTotal <= r_m_vt; oVActive <= r_m_va;
            oLocked     <= (r_state == LOCKED);
            oFrameStart <= r_fs;
            oErr        <= r_err;
        end
    end

endmodule

// File: tb/tb_video_timing_detector.sv
// tb/tb_video_timing_detector.sv - directed self-checking bench for video_timing_detector
module tb_video_timing_detector;

    // Reduced raster keeps the run short; HS/VS falls coincide at each frame start
    localparam int H_SYNC = 8, H_BP = 6, H_ACT = 64;
    localparam int HT_A = 80, HT_B = 94;
    localparam int V_SYNC = 2, V_BP = 3, V_ACT = 48, V_TOT = 55;
    localparam int TMO = 4095;

    logic        iClk = 1'b0, iRst_n = 1'b0, iDE = 1'b0, iHS = 1'b1, iVS = 1'b1;
    logic        oDE, oHS, oVS, oLocked, oFrameStart, oErr;
    logic [11:0] oX, oHTotal, oHActive;
    logic [10:0] oY, oVTotal, oVActive;

    video_timing_detector #(.LOCK_FRAMES(2), .TIMEOUT(TMO)) dut (
        .iClk(iClk), .iRst_n(iRst_n), .iDE(iDE), .iHS(iHS), .iVS(iVS),
        .oDE(oDE), .oHS(oHS), .oVS(oVS), .oX(oX), .oY(oY),
        .oHTotal(oHTotal), .oHActive(oHActive), .oVTotal(oVTotal), .oVActive(oVActive),
        .oLocked(oLocked), .oFrameStart(oFrameStart), .oErr(oErr)
    );

    always #5 iClk = ~iClk;

    int n_checks = 0, n_errors = 0;
    int cyc = 0;
    int vs_cyc = 0, last_hs = 0, t_first = -1, t_last = -1;
    int fs_cnt = 0, fs_cyc = -1, err_cnt = 0, err_cyc = -1, lock_rise_cyc = -1;
    logic lock_at_err = 1'b1, prev_lock = 1'b0;
    logic [11:0] sf_x = '1, sl_x = '1;
    logic [10:0] sf_y = '1, sl_y = '1;
    logic sf_de = 1'b0;

    always @(posedge iClk) cyc <= cyc + 1;

    always @(negedge iClk) begin
        if (oFrameStart) begin fs_cnt++; fs_cyc = cyc; end
        if (oErr) begin err_cnt++; err_cyc = cyc; lock_at_err = oLocked; end
        if (oLocked && !prev_lock) lock_rise_cyc = cyc;
        prev_lock = oLocked;
        if (cyc == t_first) begin sf_x = oX; sf_y = oY; sf_de = oDE; end
        if (cyc == t_last)  begin sl_x = oX; sl_y = oY; end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic gen_pixels(input int htot, input int ln, input int h0, input int h1);
        int s;
        for (int h = h0; h < h1 && h < htot; h++) begin
            s = cyc + 1;
            if (h == 0) last_hs = s;
            if (h == 0 && ln == 0) vs_cyc = s;
            if (ln == V_SYNC + V_BP && h == H_SYNC + H_BP) t_first = s + 2;
            if (ln == V_SYNC + V_BP + V_ACT - 1 && h == H_SYNC + H_BP + H_ACT - 1) t_last = s + 2;
            iHS = (h >= H_SYNC);
            iVS = (ln >= V_SYNC);
            iDE = (ln >= V_SYNC + V_BP) && (ln < V_SYNC + V_BP + V_ACT) &&
                  (h >= H_SYNC + H_BP) && (h < H_SYNC + H_BP + H_ACT);
            @(posedge iClk); #1;
        end
    endtask

    task automatic gen_lines(input int htot, input int first, input int n);
        for (int l = first; l < first + n; l++) gen_pixels(htot, l, 0, htot);
    endtask

    task automatic idle(input int n);
        iDE = 1'b0; iHS = 1'b1; iVS = 1'b1;
        repeat (n) begin @(posedge iClk); #1; end
    endtask

    int fs_base;

    initial begin
        repeat (3) @(posedge iClk);
        #1;
        check("rst_oDE", oDE, 0);          check("rst_oHS", oHS, 1);
        check("rst_oVS", oVS, 1);          check("rst_oX", oX, 0);
        check("rst_oY", oY, 0);            check("rst_oHTotal", oHTotal, 0);
        check("rst_oVTotal", oVTotal, 0);  check("rst_oLocked", oLocked, 0);
        check("rst_oFrameStart", oFrameStart, 0);
        check("rst_oErr", oErr, 0);
        iRst_n = 1'b1;
        idle(5);

        // Lock on standard timing: third VS fall locks
        gen_lines(HT_A, 0, V_TOT);
        gen_lines(HT_A, 0, V_TOT);
        check("acq_not_locked", oLocked, 0);
        check("first_px_oX", sf_x, 0);
        check("first_px_oY", sf_y, 0);
        check("first_px_oDE", sf_de, 1);
        check("last_px_oX", sl_x, H_ACT - 1);
        check("last_px_oY", sl_y, V_ACT - 1);
        gen_lines(HT_A, 0, V_TOT);
        check("lock_latency", lock_rise_cyc, vs_cyc + 2);
        check("fs_latency", fs_cyc, vs_cyc + 2);
        check("fs_count", fs_cnt, 3);
        check("locked_A", oLocked, 1);
        check("oHTotal_A", oHTotal, HT_A);
        check("oHActive_A", oHActive, H_ACT);
        check("oVTotal_A_coincident", oVTotal, V_TOT);
        check("oVActive_A", oVActive, V_ACT);

        // Geometry change: wider line total
        gen_lines(HT_B, 0, V_TOT);
        check("still_locked", oLocked, 1);
        check("no_err_yet", err_cnt, 0);
        gen_lines(HT_B, 0, V_TOT);
        check("geo_err_count", err_cnt, 1);
        check("geo_err_latency", err_cyc, vs_cyc + 2);
        check("geo_lock_at_err", lock_at_err, 0);
        check("geo_unlocked", oLocked, 0);
        gen_lines(HT_B, 0, V_TOT);
        check("relock_latency", lock_rise_cyc, vs_cyc + 2);
        check("relock_oHTotal", oHTotal, HT_B);
        check("relocked", oLocked, 1);

        // Sync loss: HS held high while locked
        gen_lines(HT_B, 0, 3);
        idle(4300);
        check("tmo_err_count", err_cnt, 2);
        check("tmo_err_latency", err_cyc, last_hs + TMO + 2);
        check("tmo_unlocked", oLocked, 0);

        // Asynchronous reset mid-line with nonzero state
        gen_lines(HT_A, 0, 40);
        gen_pixels(HT_A, 40, 0, 30);
        check("pre_rst_oHTotal", oHTotal, HT_B);
        iRst_n = 1'b0;
        #1;
        check("arst_oDE", oDE, 0);          check("arst_oHS", oHS, 1);
        check("arst_oVS", oVS, 1);          check("arst_oX", oX, 0);
        check("arst_oY", oY, 0);            check("arst_oHTotal", oHTotal, 0);
        check("arst_oHActive", oHActive, 0); check("arst_oVActive", oVActive, 0);
        check("arst_oLocked", oLocked, 0);
        @(posedge iClk); #1;
        iRst_n = 1'b1;
        fs_base = fs_cnt;
        gen_pixels(HT_A, 40, 30, HT_A);
        gen_lines(HT_A, 41, V_TOT - 41);
        check("no_spurious_fs", fs_cnt - fs_base, 0);
        check("arst_still_unlocked", oLocked, 0);
        gen_lines(HT_A, 0, 1);
        check("fs_after_rst", fs_cnt - fs_base, 1);
        check("fs_after_rst_latency", fs_cyc, vs_cyc + 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
